// File: rtl/alu_shared_arbiter_if.sv
// Command/response bundle between two requesters and the shared-ALU arbiter.
interface alu_shared_arbiter_if;
  logic       req0;
  logic [2:0] op0;
  logic [3:0] a0;
  logic [3:0] b0;
  logic       req1;
  logic [2:0] op1;
  logic [3:0] a1;
  logic [3:0] b1;
  logic       ack0;
  logic       ack1;
  logic       done0;
  logic       done1;
  logic [3:0] result;
  logic       zero;
  logic       busy;

  modport master (
    output req0, op0, a0, b0, req1, op1, a1, b1,
    input  ack0, ack1, done0, done1, result, zero, busy
  );

  modport slave (
    input  req0, op0, a0, b0, req1, op1, a1, b1,
    output ack0, ack1, done0, done1, result, zero, busy
  );
endinterface

// File: rtl/alu_shared_arbiter.sv
// Round-robin sharing of one 4-bit, 8-operation ALU between two requesters,
// with a multicycle EXEC phase and registered result/zero/done outputs.
module alu_shared_arbiter_alu (
  input  logic [2:0] op,
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [3:0] y
);
  always_comb begin
    y = '0;
    unique case (op)
      3'd0:    y = a + b;
      3'd1:    y = a - b;
      // shift count is the full 4-bit b; anything past 3 clears every bit
      3'd2:    y = (b > 4'd3) ? 4'd0 : (a << b[1:0]);
      3'd3:    y = (b > 4'd3) ? 4'd0 : (a >> b[1:0]);
      3'd4:    y = a & b;
      3'd5:    y = a | b;
      3'd6:    y = a ^ b;
      default: y = ~a;
    endcase
  end
endmodule

module alu_shared_arbiter #(
  parameter int EXEC_CYCLES = 1
) (
  input logic clk,
  input logic rst,
  alu_shared_arbiter_if.slave bus
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  localparam logic [3:0] LAST_CNT = 4'(EXEC_CYCLES - 1);

  logic [1:0] state;
  logic [3:0] cnt;
  logic       last_grant;
  logic       gnt;
  logic       grant_next;
  logic [2:0] op_q;
  logic [3:0] a_q;
  logic [3:0] b_q;
  logic [3:0] alu_y;
  logic [3:0] result_q;
  logic       zero_q;
  logic       ack0_q;
  logic       ack1_q;
  logic       done0_q;
  logic       done1_q;

  // on a tie, serve whoever was not served last
  always_comb grant_next = (bus.req0 && bus.req1) ? ~last_grant : bus.req1;

  alu_shared_arbiter_alu u_alu (
    .op (op_q),
    .a  (a_q),
    .b  (b_q),
    .y  (alu_y)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      last_grant <= 1'b1;
      gnt        <= 1'b0;
      op_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      result_q   <= '0;
      zero_q     <= 1'b0;
      ack0_q     <= 1'b0;
      ack1_q     <= 1'b0;
      done0_q    <= 1'b0;
      done1_q    <= 1'b0;
    end else begin
      ack0_q  <= 1'b0;
      ack1_q  <= 1'b0;
      done0_q <= 1'b0;
      done1_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.req0 || bus.req1) begin
            gnt        <= grant_next;
            last_grant <= grant_next;
            op_q       <= grant_next ? bus.op1 : bus.op0;
            a_q        <= grant_next ? bus.a1  : bus.a0;
            b_q        <= grant_next ? bus.b1  : bus.b0;
            cnt        <= '0;
            ack0_q     <= ~grant_next;
            ack1_q     <= grant_next;
            state      <= EXEC;
          end
        end
        EXEC: begin
          cnt <= cnt + 4'd1;
          if (cnt == LAST_CNT) begin
            result_q <= alu_y;
            zero_q   <= (alu_y == 4'd0);
            done0_q  <= ~gnt;
            done1_q  <= gnt;
            state    <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.ack0   = ack0_q;
  assign bus.ack1   = ack1_q;
  assign bus.done0  = done0_q;
  assign bus.done1  = done1_q;
  assign bus.result = result_q;
  assign bus.zero   = zero_q;
  assign bus.busy   = (state != IDLE);
endmodule

// File: tb/tb_alu_shared_arbiter.sv
// Drives two arbiter instances (EXEC_CYCLES 1 and 4) with identical stimulus and
// compares every output against a transaction-timeline reference model.
module tb_alu_shared_arbiter;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req0 = 1'b0;
  logic       req1 = 1'b0;
  logic [2:0] op0 = '0;
  logic [2:0] op1 = '0;
  logic [3:0] a0 = '0;
  logic [3:0] b0 = '0;
  logic [3:0] a1 = '0;
  logic [3:0] b1 = '0;
  int vectors = 0;
  int miscompares = 0;

  alu_shared_arbiter_if bus1 ();
  alu_shared_arbiter_if bus4 ();

  assign bus1.req0 = req0;  assign bus1.op0 = op0;  assign bus1.a0 = a0;  assign bus1.b0 = b0;
  assign bus1.req1 = req1;  assign bus1.op1 = op1;  assign bus1.a1 = a1;  assign bus1.b1 = b1;
  assign bus4.req0 = req0;  assign bus4.op0 = op0;  assign bus4.a0 = a0;  assign bus4.b0 = b0;
  assign bus4.req1 = req1;  assign bus4.op1 = op1;  assign bus4.a1 = a1;  assign bus4.b1 = b1;

  alu_shared_arbiter #(.EXEC_CYCLES(1)) u1 (.clk(clk), .rst(rst), .bus(bus1));
  alu_shared_arbiter #(.EXEC_CYCLES(4)) u4 (.clk(clk), .rst(rst), .bus(bus4));

  always #5 clk = ~clk;

  // {ack0, ack1, done0, done1, busy, zero, result}
  logic [9:0] obs [2];
  assign obs[0] = {bus1.ack0, bus1.ack1, bus1.done0, bus1.done1, bus1.busy, bus1.zero, bus1.result};
  assign obs[1] = {bus4.ack0, bus4.ack1, bus4.done0, bus4.done1, bus4.busy, bus4.zero, bus4.result};

  function automatic int ref_alu(int op, int a, int b);
    case (op)
      0:       return (a + b) % 16;
      1:       return (a - b + 16) % 16;
      2:       return (b >= 4) ? 0 : (a * (1 << b)) % 16;
      3:       return (b >= 4) ? 0 : a / (1 << b);
      4:       return a & b;
      5:       return a | b;
      6:       return a ^ b;
      default: return 15 - a;
    endcase
  endfunction

  // Reference: a capture at edge n books the ALU until edge n+E+2 and
  // schedules its result for edge n+E.
  int         cyc = 0;
  int         ecyc [2] = '{1, 4};
  int         free_at [2] = '{0, 0};
  int         done_at [2] = '{-1, -1};
  bit         pend [2] = '{1'b0, 1'b0};
  bit         last [2] = '{1'b1, 1'b1};
  bit         pid [2] = '{1'b0, 1'b0};
  int         pres [2] = '{0, 0};
  int         res [2] = '{0, 0};
  bit         zf [2] = '{1'b0, 1'b0};
  logic [9:0] exp_v [2] = '{10'd0, 10'd0};
  bit         k0, k1, d0, d1, g;

  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      for (int d = 0; d < 2; d++) begin
        free_at[d] = 0; pend[d] = 1'b0; last[d] = 1'b1;
        res[d] = 0; zf[d] = 1'b0; exp_v[d] = '0;
      end
    end else begin
      cyc++;
      for (int d = 0; d < 2; d++) begin
        k0 = 1'b0; k1 = 1'b0; d0 = 1'b0; d1 = 1'b0;
        if (pend[d] && cyc == done_at[d]) begin
          res[d] = pres[d];
          zf[d] = (pres[d] == 0);
          pend[d] = 1'b0;
          if (pid[d]) d1 = 1'b1; else d0 = 1'b1;
        end
        if (cyc >= free_at[d] && (req0 || req1)) begin
          g = (req0 && req1) ? !last[d] : req1;
          last[d] = g;
          pid[d] = g;
          pend[d] = 1'b1;
          pres[d] = g ? ref_alu(op1, a1, b1) : ref_alu(op0, a0, b0);
          done_at[d] = cyc + ecyc[d];
          free_at[d] = cyc + ecyc[d] + 2;
          if (g) k1 = 1'b1; else k0 = 1'b1;
        end
        exp_v[d] = {k0, k1, d0, d1, (cyc < free_at[d] - 1), zf[d], 4'(res[d])};
      end
    end
  end

  task automatic test_reset();
    rst = 1'b1; req0 = 1'b0; req1 = 1'b0;
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      vectors++;
      if (obs[d] !== 10'd0) begin
        miscompares++;
        $display("FAIL reset d%0d: got %b want %b", d, obs[d], 10'd0);
      end
    end
    rst = 1'b0;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      vectors++;
      if (obs[d] !== exp_v[d]) begin
        miscompares++;
        $display("FAIL reset_idle d%0d: got %b want %b", d, obs[d], exp_v[d]);
      end
    end
  endtask

  task automatic test_ops();
    logic [14:0] vecs [8];
    logic [14:0] v;
    logic [3:0]  want;
    logic        wz;
    vecs = '{{3'd0, 4'd9, 4'd8, 4'd1}, {3'd1, 4'd3, 4'd3, 4'd0},
             {3'd1, 4'd2, 4'd5, 4'd13}, {3'd2, 4'd3, 4'd1, 4'd6},
             {3'd2, 4'd15, 4'd4, 4'd0}, {3'd3, 4'd8, 4'd3, 4'd1},
             {3'd7, 4'd5, 4'd9, 4'd10}, {3'd6, 4'd12, 4'd10, 4'd6}};
    for (int i = 0; i < 8; i++) begin
      v = vecs[i];
      {op0, a0, b0} = v[14:4];
      want = v[3:0];
      wz = (want == 4'd0);
      req0 = 1'b1;
      for (int c = 0; c < 7; c++) begin
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
          vectors++;
          if (obs[d] !== exp_v[d]) begin
            miscompares++;
            $display("FAIL ops%0d d%0d c%0d: got %b want %b", i, d, c, obs[d], exp_v[d]);
          end
        end
        if (c == 0) begin
          req0 = 1'b0;
          vectors++;
          if ({bus1.ack0, bus4.ack0} !== 2'b11) begin
            miscompares++;
            $display("FAIL ops%0d ack0: got %b want 11", i, {bus1.ack0, bus4.ack0});
          end
        end
        if (c == 1) begin
          vectors++;
          if ({bus1.done0, bus1.zero, bus1.result} !== {1'b1, wz, want}) begin
            miscompares++;
            $display("FAIL ops%0d e1 result: got %b want %b", i,
                     {bus1.done0, bus1.zero, bus1.result}, {1'b1, wz, want});
          end
        end
        if (c == 2) begin
          vectors++;
          if (bus1.busy !== 1'b0) begin
            miscompares++;
            $display("FAIL ops%0d e1 busy: got %b want 0", i, bus1.busy);
          end
        end
        if (c == 4) begin
          vectors++;
          if ({bus4.done0, bus4.zero, bus4.result} !== {1'b1, wz, want}) begin
            miscompares++;
            $display("FAIL ops%0d e4 result: got %b want %b", i,
                     {bus4.done0, bus4.zero, bus4.result}, {1'b1, wz, want});
          end
        end
      end
    end
  endtask

  task automatic test_alternate();
    bit id1 [$];
    bit id4 [$];
    int t1 [$];
    int t4 [$];
    req0 = 1'b1; req1 = 1'b1;
    for (int c = 0; c < 40; c++) begin
      {op0, a0, b0, op1, b1} = 18'($urandom);
      a1 = a0 ^ 4'd5;
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        vectors++;
        if (obs[d] !== exp_v[d]) begin
          miscompares++;
          $display("FAIL alt d%0d c%0d: got %b want %b", d, c, obs[d], exp_v[d]);
        end
      end
      if (bus1.ack0 || bus1.ack1) begin id1.push_back(bus1.ack1); t1.push_back(cyc); end
      if (bus4.ack0 || bus4.ack1) begin id4.push_back(bus4.ack1); t4.push_back(cyc); end
    end
    req0 = 1'b0; req1 = 1'b0;
    vectors++;
    if (id1.size() < 10 || id4.size() < 5) begin
      miscompares++;
      $display("FAIL alt grant count: got %0d/%0d want >=10/>=5", id1.size(), id4.size());
    end
    for (int i = 1; i < id1.size(); i++) begin
      vectors++;
      if (id1[i] == id1[i-1] || t1[i] - t1[i-1] != 3) begin
        miscompares++;
        $display("FAIL alt e1 grant%0d: got id %0d gap %0d want id %0d gap 3", i,
                 id1[i], t1[i] - t1[i-1], !id1[i-1]);
      end
    end
    for (int i = 1; i < id4.size(); i++) begin
      vectors++;
      if (id4[i] == id4[i-1] || t4[i] - t4[i-1] != 6) begin
        miscompares++;
        $display("FAIL alt e4 grant%0d: got id %0d gap %0d want id %0d gap 6", i,
                 id4[i], t4[i] - t4[i-1], !id4[i-1]);
      end
    end
    repeat (8) @(negedge clk);
  endtask

  task automatic test_reset_mid_exec();
    {op0, a0, b0, op1, a1, b1} = 22'($urandom);
    req0 = 1'b1; req1 = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    for (int d = 0; d < 2; d++) begin
      vectors++;
      if (obs[d] !== 10'd0) begin
        miscompares++;
        $display("FAIL rst_mid d%0d: got %b want %b", d, obs[d], 10'd0);
      end
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    vectors++;
    if ({bus1.ack0, bus1.ack1, bus4.ack0, bus4.ack1} !== 4'b1010) begin
      miscompares++;
      $display("FAIL rst_first_grant: got %b want 1010",
               {bus1.ack0, bus1.ack1, bus4.ack0, bus4.ack1});
    end
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        vectors++;
        if (obs[d] !== exp_v[d]) begin
          miscompares++;
          $display("FAIL rst_after d%0d c%0d: got %b want %b", d, c, obs[d], exp_v[d]);
        end
      end
    end
    req0 = 1'b0; req1 = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic test_ignore();
    {op0, a0, b0, op1, a1, b1} = 22'($urandom);
    req0 = 1'b1;
    for (int c = 0; c < 11; c++) begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        vectors++;
        if (obs[d] !== exp_v[d]) begin
          miscompares++;
          $display("FAIL ign d%0d c%0d: got %b want %b", d, c, obs[d], exp_v[d]);
        end
      end
      if (c < 3) begin
        vectors++;
        if (bus1.ack1 !== 1'b0) begin
          miscompares++;
          $display("FAIL ign early_ack1 c%0d: got %b want 0", c, bus1.ack1);
        end
      end
      if (c == 3) begin
        vectors++;
        if (bus1.ack1 !== 1'b1) begin
          miscompares++;
          $display("FAIL ign idle_ack1: got %b want 1", bus1.ack1);
        end
        req1 = 1'b0;
      end
      if (c >= 5) begin
        vectors++;
        if (bus1.ack0 !== 1'b0 || bus4.ack0 !== 1'b0) begin
          miscompares++;
          $display("FAIL ign done_req0 c%0d: got %b%b want 00", c, bus1.ack0, bus4.ack0);
        end
      end
      if (c == 0) begin req0 = 1'b0; req1 = 1'b1; end
      if (c == 4) req0 = 1'b1;
      if (c == 5) req0 = 1'b0;
    end
    repeat (8) @(negedge clk);
  endtask

  task automatic test_random();
    for (int c = 0; c < 500; c++) begin
      {op0, a0, b0, op1, a1, b1} = 22'($urandom);
      req0 = ($urandom_range(0, 2) != 0);
      req1 = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 79) == 0) begin
        #2 rst = 1'b1;
        #1;
        for (int d = 0; d < 2; d++) begin
          vectors++;
          if (obs[d] !== exp_v[d]) begin
            miscompares++;
            $display("FAIL rnd_rst d%0d c%0d: got %b want %b", d, c, obs[d], exp_v[d]);
          end
        end
        @(negedge clk);
        rst = 1'b0;
      end
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        vectors++;
        if (obs[d] !== exp_v[d]) begin
          miscompares++;
          $display("FAIL rnd d%0d c%0d: got %b want %b", d, c, obs[d], exp_v[d]);
        end
      end
    end
    req0 = 1'b0; req1 = 1'b0;
  endtask

  initial begin
    test_reset();
    test_ops();
    test_alternate();
    test_reset_mid_exec();
    test_ignore();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
